// File: rtl/matrix_stream_loader_pkg.sv
// Shared types and constants for the operand loader that feeds the complex
// 8x8 matrix-multiply stage.
package matrix_stream_loader_pkg;

    localparam int WORD_LEN    = 16;
    localparam int ADDR_BITS   = 7;
    localparam int N_ELEM      = 64;
    localparam int KICK_CYCLES = 5;

    localparam int CNT_BITS  = $clog2(N_ELEM);
    localparam int KICK_BITS = $clog2(KICK_CYCLES + 1);

    // Write-enable bit positions on the memory side.
    localparam int WE_AR = 0;
    localparam int WE_BR = 1;
    localparam int WE_AI = 2;
    localparam int WE_BI = 3;

    typedef logic signed [WORD_LEN-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LD_AR,
        LD_AI,
        LD_BR,
        LD_BI,
        KICK,
        DONE
    } state_t;

    function automatic logic [3:0] phase_we(input state_t s);
        logic [3:0] w;
        w = '0;
        case (s)
            LD_AR:   w[WE_AR] = 1'b1;
            LD_AI:   w[WE_AI] = 1'b1;
            LD_BR:   w[WE_BR] = 1'b1;
            LD_BI:   w[WE_BI] = 1'b1;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Operand stream in, operand-memory write bus out.
interface matrix_stream_loader_if;
    import matrix_stream_loader_pkg::*;

    word_t                in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           we;
    logic [ADDR_BITS-1:0] Dir_M1;
    logic [ADDR_BITS-1:0] Dir_M2;
    word_t                data_m1_real;
    word_t                data_m1_imag;
    word_t                data_m2_real;
    word_t                data_m2_imag;

    // Stream source and memory observer.
    modport master (
        output in_data, in_valid,
        input  in_ready, we, Dir_M1, Dir_M2,
        input  data_m1_real, data_m1_imag, data_m2_real, data_m2_imag
    );

    // The loader.
    modport slave (
        input  in_data, in_valid,
        output in_ready, we, Dir_M1, Dir_M2,
        output data_m1_real, data_m1_imag, data_m2_real, data_m2_imag
    );

endinterface

// File: rtl/matrix_stream_loader_elem_counter.sv
// Element index within one matrix plane; wrap marks the last beat of a plane.
module matrix_stream_loader_elem_counter
    import matrix_stream_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count,
    output logic                wrap
);

    assign wrap = inc && (count == CNT_BITS'(N_ELEM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Loads A re, A im, B re, B im (64 words each) from one stream, then pulses
// the multiply stage's active-low reset and reports load_done.
module matrix_stream_loader
    import matrix_stream_loader_pkg::*;
(
    input  logic                  src_clk,
    input  logic                  rst,
    input  logic                  start,
    matrix_stream_loader_if.slave bus,
    output logic                  compute_rst_n,
    output logic                  load_done
);

    state_t               state;
    state_t               state_next;
    logic                 accept;
    logic                 wrap;
    logic [CNT_BITS-1:0]  elem;
    logic [KICK_BITS-1:0] kick_cnt;

    assign bus.in_ready = (state == LD_AR) || (state == LD_AI) ||
                          (state == LD_BR) || (state == LD_BI);
    assign accept       = bus.in_valid && bus.in_ready;

    matrix_stream_loader_elem_counter u_elem_counter (
        .clk   (src_clk),
        .rst_n (rst),
        .inc   (accept),
        .count (elem),
        .wrap  (wrap)
    );

    always_ff @(posedge src_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LD_AR;
            LD_AR:   if (wrap)  state_next = LD_AI;
            LD_AI:   if (wrap)  state_next = LD_BR;
            LD_BR:   if (wrap)  state_next = LD_BI;
            LD_BI:   if (wrap)  state_next = KICK;
            KICK:    if (kick_cnt == KICK_BITS'(KICK_CYCLES)) state_next = DONE;
            DONE:    if (start) state_next = LD_AR;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge src_clk or negedge rst) begin
        if (!rst) begin
            bus.we           <= '0;
            bus.Dir_M1       <= '0;
            bus.Dir_M2       <= '0;
            bus.data_m1_real <= '0;
            bus.data_m1_imag <= '0;
            bus.data_m2_real <= '0;
            bus.data_m2_imag <= '0;
            kick_cnt         <= '0;
            compute_rst_n    <= 1'b1;
            load_done        <= 1'b0;
        end else begin
            // The write for an accepted beat is presented in the following cycle.
            bus.we <= accept ? phase_we(state) : 4'b0000;
            if (accept) begin
                case (state)
                    LD_AR: begin
                        bus.Dir_M1       <= ADDR_BITS'(elem);
                        bus.data_m1_real <= bus.in_data;
                    end
                    LD_AI: begin
                        bus.Dir_M1       <= ADDR_BITS'(elem);
                        bus.data_m1_imag <= bus.in_data;
                    end
                    LD_BR: begin
                        bus.Dir_M2       <= ADDR_BITS'(elem);
                        bus.data_m2_real <= bus.in_data;
                    end
                    LD_BI: begin
                        bus.Dir_M2       <= ADDR_BITS'(elem);
                        bus.data_m2_imag <= bus.in_data;
                    end
                    default: ;
                endcase
            end

            // First KICK cycle carries the last B-imag write; the pulse follows it.
            kick_cnt      <= (state == KICK) ? kick_cnt + 1'b1 : '0;
            compute_rst_n <= !((state == KICK) && (kick_cnt < KICK_BITS'(KICK_CYCLES)));
            load_done     <= (state_next == DONE);
        end
    end

endmodule
